pad_state_sender: RTL and testbench

PAD_STATE_SENDER -- requirements
Module: pad_state_sender

---
 rtl/pad_state_sender.sv | 234 +++++++++++++++++++++++
 tb/tb_pad_state_sender.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_state_sender.sv
// pad_state_sender
//   Sends the SHA1 ipad/opad initial-state pair of one candidate across an
//   asynchronous boundary. The ipad goes first, then the opad. Each word
//   uses a 4-phase request/acknowledge handshake.
//
// Ports
//   clk            : single clock for all logic
//   global_reset_n : asynchronous active-low reset
//   in_ipad[159:0] : ipad initial state of the offered candidate
//   in_opad[159:0] : opad initial state of the same candidate
//   in_valid       : offered pair is valid
//   in_ready       : the pair is accepted on a clk edge where in_valid and
//                    in_ready are both high
//   iopad_hash     : registered pad state presented to the hash pipe
//   pad_type       : 0 = ipad, 1 = opad (registered)
//   iready         : registered request strobe of the 4-phase handshake
//   readack        : asynchronous acknowledge from the hash pipe
//   busy           : FSM not in IDLE, or a pair is buffered
//   pairs_sent     : count of fully acknowledged ipad+opad pairs (wraps)
//   fsm_state_o    : debug view of the FSM state encoding
//
// Input handshake: a transfer happens on every rising clk edge where
// in_valid=1 and in_ready=1. in_ready is derived only from registers. The
// producer must keep in_ipad/in_opad stable while in_valid is high.
//
// Build option PAD_SENDER_PREFETCH_EN adds a second pair slot. With it,
// in_ready stays high while that slot is empty, including during an
// active handshake. The next pair then goes from REL_O straight into
// LOAD_I, with no IDLE cycle in between. Without it, only one pair is
// held, and in_ready is high only in IDLE with no pair buffered.

module pad_state_sender (
  input  logic         clk,
  input  logic         global_reset_n,
  input  logic [159:0] in_ipad,
  input  logic [159:0] in_opad,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [159:0] iopad_hash,
  output logic         pad_type,
  output logic         iready,
  input  logic         readack,
  output logic         busy,
  output logic [31:0]  pairs_sent,
  output logic [2:0]   fsm_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    REQ_I  = 3'd2,
    REL_I  = 3'd3,
    LOAD_O = 3'd4,
    REQ_O  = 3'd5,
    REL_O  = 3'd6
  } state_e;

  state_e        state_q;
  logic          ack_meta_q;
  logic          ack_q;
  logic          run_q;
  logic          iready_q;
  logic          pad_type_q;
  logic [159:0]  iopad_hash_q;
  logic [31:0]   pairs_sent_q;

  // slot0 holds the pair currently being sent. It stays valid until REL_O exits.
  logic          slot0_valid_q;
  logic [159:0]  slot0_ipad_q;
  logic [159:0]  slot0_opad_q;

  logic          accept;
  logic          rel_o_done;
  logic          next_pair_ready;
  logic [159:0]  next_ipad;

  // readack is asynchronous. Only ack_q, the synchronized copy, is used.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      ack_meta_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_meta_q <= readack;
      ack_q      <= ack_meta_q;
    end
  end

  // run_q holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign accept     = in_valid & in_ready;
  assign rel_o_done = (state_q == REL_O) & ~ack_q;

`ifdef PAD_SENDER_PREFETCH_EN
  logic          slot1_valid_q;
  logic [159:0]  slot1_ipad_q;
  logic [159:0]  slot1_opad_q;

  assign in_ready        = run_q & ~slot1_valid_q;
  assign next_pair_ready = slot1_valid_q;
  assign next_ipad       = slot1_ipad_q;

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      slot0_valid_q <= 1'b0;
      slot0_ipad_q  <= '0;
      slot0_opad_q  <= '0;
      slot1_valid_q <= 1'b0;
      slot1_ipad_q  <= '0;
      slot1_opad_q  <= '0;
    end else if (rel_o_done) begin
      if (slot1_valid_q) begin
        // Promote the prefetched pair. in_ready is low, so nothing is accepted.
        slot0_ipad_q  <= slot1_ipad_q;
        slot0_opad_q  <= slot1_opad_q;
        slot1_valid_q <= 1'b0;
      end else begin
        slot0_valid_q <= accept;
        if (accept) begin
          slot0_ipad_q <= in_ipad;
          slot0_opad_q <= in_opad;
        end
      end
    end else if (accept) begin
      if (!slot0_valid_q) begin
        slot0_valid_q <= 1'b1;
        slot0_ipad_q  <= in_ipad;
        slot0_opad_q  <= in_opad;
      end else begin
        slot1_valid_q <= 1'b1;
        slot1_ipad_q  <= in_ipad;
        slot1_opad_q  <= in_opad;
      end
    end
  end
`else
  assign in_ready        = run_q & (state_q == IDLE) & ~slot0_valid_q;
  assign next_pair_ready = 1'b0;
  assign next_ipad       = slot0_ipad_q;

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      slot0_valid_q <= 1'b0;
      slot0_ipad_q  <= '0;
      slot0_opad_q  <= '0;
    end else if (rel_o_done) begin
      slot0_valid_q <= 1'b0;
    end else if (accept) begin
      slot0_valid_q <= 1'b1;
      slot0_ipad_q  <= in_ipad;
      slot0_opad_q  <= in_opad;
    end
  end
`endif

  // Data and pad_type are loaded on the edge that enters LOAD_x.
  // iready rises one edge later, so the data is settled before the request.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q      <= IDLE;
      iready_q     <= 1'b0;
      pad_type_q   <= 1'b0;
      iopad_hash_q <= '0;
      pairs_sent_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (slot0_valid_q && !ack_q) begin
            state_q      <= LOAD_I;
            iopad_hash_q <= slot0_ipad_q;
            pad_type_q   <= 1'b0;
          end
        end
        LOAD_I: begin
          state_q  <= REQ_I;
          iready_q <= 1'b1;
        end
        REQ_I: begin
          if (ack_q) begin
            state_q  <= REL_I;
            iready_q <= 1'b0;
          end
        end
        REL_I: begin
          if (!ack_q) begin
            state_q      <= LOAD_O;
            iopad_hash_q <= slot0_opad_q;
            pad_type_q   <= 1'b1;
          end
        end
        LOAD_O: begin
          state_q  <= REQ_O;
          iready_q <= 1'b1;
        end
        REQ_O: begin
          if (ack_q) begin
            state_q  <= REL_O;
            iready_q <= 1'b0;
          end
        end
        REL_O: begin
          if (!ack_q) begin
            pairs_sent_q <= pairs_sent_q + 32'd1;
            if (next_pair_ready) begin
              state_q      <= LOAD_I;
              iopad_hash_q <= next_ipad;
              pad_type_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          iready_q <= 1'b0;
        end
      endcase
    end
  end

  assign iready      = iready_q;
  assign pad_type    = pad_type_q;
  assign iopad_hash  = iopad_hash_q;
  assign pairs_sent  = pairs_sent_q;
  assign busy        = (state_q != IDLE) | slot0_valid_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pad_state_sender.sv
// tb_pad_state_sender
//   Directed bench for pad_state_sender. A scoreboard queue holds the
//   expected {pad_type, iopad_hash} words in the order they should appear.
//   A responder task plays the hash-pipe side of the 4-phase handshake.

module tb_pad_state_sender;

  localparam int W = 161;

  // clock / reset
  logic         clk;
  logic         global_reset_n;
  logic [159:0] in_ipad;
  logic [159:0] in_opad;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] iopad_hash;
  logic         pad_type;
  logic         iready;
  logic         readack;
  logic         busy;
  logic [31:0]  pairs_sent;
  logic [2:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;
  logic         mon_done;
  int           mon_bad;
  logic [31:0]  base_cnt;

  pad_state_sender dut (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .in_ipad        (in_ipad),
    .in_opad        (in_opad),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .iopad_hash     (iopad_hash),
    .pad_type       (pad_type),
    .iready         (iready),
    .readack        (readack),
    .busy           (busy),
    .pairs_sent     (pairs_sent),
    .fsm_state_o    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: offer one pair at a negedge, return at the negedge after it is taken
  task automatic send_pair(input logic [159:0] ip, input logic [159:0] op);
    int t;
    t = 0;
    in_ipad  = ip;
    in_opad  = op;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back({1'b0, ip});
    exp_q.push_back({1'b1, op});
  endtask

  // responder: serve one request word, ack after ack_delay cycles, keep
  // readack high for hold cycles after iready falls
  task automatic serve(input int ack_delay, input int hold);
    logic [W-1:0] exp;
    int t;
    int bad;
    t = 0;
    exp = '0;
    while (iready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("iready_rise", iready, 1);
    check("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check("pad_data", {pad_type, iopad_hash}, exp);
    repeat (ack_delay) @(negedge clk);
    readack = 1'b1;
    t = 0;
    while (iready !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("iready_fall", iready, 0);
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (iready !== 1'b0 || {pad_type, iopad_hash} !== exp ||
          dbg_state !== (exp[W-1] ? 3'd6 : 3'd3)) bad++;
    end
    if (hold > 0) check("rel_hold", bad, 0);
    readack = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((dbg_state !== 3'd0 || busy !== 1'b0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", {dbg_state, busy}, 4'b0000);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    global_reset_n = 1'b0;
    in_ipad        = '0;
    in_opad        = '0;
    in_valid       = 1'b0;
    readack        = 1'b0;
    mon_done       = 1'b0;
    mon_bad        = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_iready", iready, 0);
    check("rst_pad_type", pad_type, 0);
    check("rst_hash", iopad_hash, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pairs", pairs_sent, 0);
    check("rst_state", dbg_state, 0);
    global_reset_n = 1'b1;
    #1 check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("in_ready_up", in_ready, 1);

    // one pair (1,2), ack after 3 cycles, with latency checks
    send_pair(160'h1, 160'h2);
    check("lat_n_state", dbg_state, 0);
    check("lat_n_busy", busy, 1);
    check("lat_n_in_ready", in_ready, 0);
    @(negedge clk);
    check("lat_n1_state", dbg_state, 1);
    check("lat_n1_iready", iready, 0);
    check("lat_n1_data", {pad_type, iopad_hash}, {1'b0, 160'h1});
    @(negedge clk);
    check("lat_n2_iready", iready, 1);
    check("lat_n2_state", dbg_state, 2);
    serve(3, 0);
    serve(3, 0);
    wait_idle();
    check("pairs_one", pairs_sent, 1);

    // readack held high 20 cycles in REL_I
    send_pair({5{32'hA5A5_0001}}, {5{32'h5A5A_0002}});
    serve(2, 20);
    serve(2, 0);
    wait_idle();
    check("pairs_two", pairs_sent, 2);

    // 4 back-to-back pairs
    base_cnt = pairs_sent;
    mon_done = 1'b0;
    mon_bad  = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_pair({5{32'h1000_0000 + 32'(i)}}, {5{32'h2000_0000 + 32'(i)}});
      end
      begin
        for (int k = 0; k < 8; k++) serve(1, 0);
        mon_done = 1'b1;
      end
      begin
        while (!mon_done) begin
          @(negedge clk);
`ifdef PAD_SENDER_PREFETCH_EN
          if (dbg_state == 3'd0 && (pairs_sent - base_cnt) >= 1 && (pairs_sent - base_cnt) <= 3)
            mon_bad++;
`else
          if (in_ready && busy) mon_bad++;
`endif
        end
      end
    join
    check("b2b_monitor", mon_bad, 0);
    wait_idle();
    check("b2b_pairs", pairs_sent - base_cnt, 4);
    check("b2b_sb_empty", exp_q.size(), 0);

    // pairs_sent wrap
    force dut.pairs_sent_q = 32'hFFFF_FFFF;
    #1 release dut.pairs_sent_q;
    check("wrap_pre", pairs_sent, 32'hFFFF_FFFF);
    @(negedge clk);
    send_pair({5{32'h3333_3333}}, {5{32'h4444_4444}});
    serve(1, 0);
    serve(1, 0);
    wait_idle();
    check("wrap_post", pairs_sent, 0);

    // readack high in IDLE while a pair is buffered
    readack = 1'b1;
    repeat (3) @(negedge clk);
    send_pair({5{32'hC0C0_C0C0}}, {5{32'hD0D0_D0D0}});
    mon_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (dbg_state !== 3'd0 || iready !== 1'b0 || busy !== 1'b1) mon_bad++;
    end
    check("idle_ack_hold", mon_bad, 0);
    readack = 1'b0;
    serve(1, 0);
    serve(1, 0);
    wait_idle();
    check("idle_ack_pairs", pairs_sent, 1);

    // reset during REQ_O
    send_pair({5{32'hEEEE_0001}}, {5{32'hFFFF_0002}});
    serve(1, 0);
    begin
      int t;
      t = 0;
      while (!(iready === 1'b1 && pad_type === 1'b1) && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("reqo_state", dbg_state, 5);
    global_reset_n = 1'b0;
    #1;
    check("mid_rst_iready", iready, 0);
    check("mid_rst_pairs", pairs_sent, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    global_reset_n = 1'b1;
    #1 check("mid_rel_in_ready", in_ready, 0);
    @(negedge clk);
    send_pair({5{32'h7777_0003}}, {5{32'h8888_0004}});
    serve(1, 0);
    serve(1, 0);
    wait_idle();
    check("post_rst_pairs", pairs_sent, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
